// File: rtl/decode_stage_if.sv
// Fetch-to-execute handshake bundle for the opcode decode stage, plus its
// flush and illegal-opcode counter controls.
interface decode_stage_if #(
    parameter int OPC_W     = 5,
    parameter int INSN_W    = 32,
    parameter int PC_W      = 32,
    parameter int ERR_CNT_W = 8
);
    localparam int NUM_OPC = 2 ** OPC_W;

    logic                 in_valid;
    logic                 in_ready;
    logic [INSN_W-1:0]    in_insn;
    logic [PC_W-1:0]      in_pc;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [INSN_W-1:0]    out_insn;
    logic [PC_W-1:0]      out_pc;
    logic [NUM_OPC-1:0]   out_onehot;
    logic                 out_illegal;
    logic [ERR_CNT_W-1:0] illegal_cnt;
    logic                 clr_cnt;

    modport slave (
        input  in_valid, in_insn, in_pc, flush, out_ready, clr_cnt,
        output in_ready, out_valid, out_insn, out_pc, out_onehot, out_illegal, illegal_cnt
    );

    modport master (
        output in_valid, in_insn, in_pc, flush, out_ready, clr_cnt,
        input  in_ready, out_valid, out_insn, out_pc, out_onehot, out_illegal, illegal_cnt
    );
endinterface

// File: rtl/decode_stage.sv
// Registered opcode decode stage with a 2-entry skid buffer so in_ready comes
// straight from a flop; illegal opcodes are flagged and counted (saturating).
//
//   state | meaning
//   EMPTY | no word held
//   ONE   | word in main entry, skid empty
//   FULL  | main and skid both hold a word, in_ready low
module decode_stage #(
    parameter int                  OPC_W      = 5,
    parameter int                  INSN_W     = 32,
    parameter int                  PC_W       = 32,
    parameter logic [2**OPC_W-1:0] LEGAL_MASK = 32'h0060_7FFF,
    parameter int                  ERR_CNT_W  = 8
) (
    input logic          clock,
    input logic          reset_n,
    decode_stage_if.slave bus
);
    localparam int NUM_OPC = 2 ** OPC_W;
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [INSN_W-1:0]  insn;
        logic [PC_W-1:0]    pc;
        logic [NUM_OPC-1:0] onehot;
        logic               illegal;
    } word_t;

    state_t               state_q, state_d;
    word_t                main_q, skid_q, in_word;
    logic [OPC_W-1:0]     in_opc;
    logic [NUM_OPC-1:0]   in_onehot;
    logic                 in_illegal;
    logic                 ready, valid, accept, pop;
    logic                 load_main_in, load_main_skid, load_skid_in;
    logic [ERR_CNT_W-1:0] cnt_q;

    assign in_opc = bus.in_insn[INSN_W-1 -: OPC_W];

    always_comb begin
        in_onehot = '0;
        for (int k = 0; k < NUM_OPC; k++) begin
            in_onehot[k] = (in_opc == OPC_W'(k)) && LEGAL_MASK[k];
        end
    end

    assign in_illegal = ~LEGAL_MASK[in_opc];
    assign in_word    = '{insn: bus.in_insn, pc: bus.in_pc, onehot: in_onehot, illegal: in_illegal};

    assign ready  = (state_q != FULL);
    assign valid  = (state_q != EMPTY);
    assign accept = bus.in_valid && ready;
    assign pop    = valid && bus.out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (accept) state_d = ONE;
                ONE: begin
                    if (accept && !pop)      state_d = FULL;
                    else if (!accept && pop) state_d = EMPTY;
                end
                FULL:    if (pop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // A flushed cycle loads nothing: the accepted word is dropped and the data
    // registers keep their last contents.
    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (!bus.flush) begin
            case (state_q)
                EMPTY: load_main_in = accept;
                ONE: begin
                    load_main_in = accept && pop;
                    load_skid_in = accept && !pop;
                end
                FULL:  load_main_skid = pop;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= in_word;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid_in)        skid_q <= in_word;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (bus.clr_cnt) begin
            cnt_q <= '0;
        end else if (accept && !bus.flush && in_illegal && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.in_ready    = ready;
    assign bus.out_valid   = valid;
    assign bus.out_insn    = main_q.insn;
    assign bus.out_pc      = main_q.pc;
    assign bus.out_onehot  = main_q.onehot;
    assign bus.out_illegal = main_q.illegal;
    assign bus.illegal_cnt = cnt_q;
endmodule
